// File: rtl/noc_pkt_gen_pkg.sv
// pkt_gen_pkg: shared flit layout offsets, FSM state enum, IPv6 marker, LFSR polynomial and sop header builder
package pkt_gen_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  localparam int SOP_OFF = 0;
  localparam int EOP_OFF = 1;
  localparam int EMPTY_OFF = 2;
  localparam int EMPTY_W = 6;
  localparam int DEST_OFF = EMPTY_OFF + EMPTY_W;
  localparam logic [11:0] IPV6_MARKER = 12'h86D;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  function automatic logic [63:0] sop_header(input logic [15:0] seq, input logic [3:0] flits);
    return {32'h0, IPV6_MARKER, flits, seq};
  endfunction
endpackage

// File: rtl/noc_pkt_gen_if.sv
// noc_pkt_gen_if: NoC flit stream (o_data_out, o_valid_out, o_ready_in) with master (generator) and slave (NoC) modports
interface noc_pkt_gen_if #(parameter int NOC_WIDTH = 600) ();
  logic [NOC_WIDTH-1:0] o_data_out;
  logic o_valid_out;
  logic o_ready_in;
  modport master (output o_data_out, o_valid_out, input o_ready_in);
  modport slave (input o_data_out, o_valid_out, output o_ready_in);
endinterface

// File: rtl/noc_pkt_gen_lfsr.sv
// pkt_gen_lfsr: 32-bit Galois LFSR; ports clk, reset (async active-low, seeds 1), advance (step once), value
module pkt_gen_lfsr
  import pkt_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [31:0] value
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) value <= 32'h1;
    else if (advance) value <= value[0] ? (value >> 1) ^ LFSR_POLY : value >> 1;
endmodule

// File: rtl/noc_pkt_gen.sv
// noc_pkt_gen: NoC test packet generator; ports clk, reset (async low), i_start/i_num_pkts/i_pkt_flits run control, noc flit stream (master), o_busy/o_done/o_pkt_cnt status; PKT_GEN_LFSR_EN selects LFSR payload fill
module noc_pkt_gen
  import pkt_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int NOC_WIDTH = 600,
  parameter int NUM_VC = 2,
  parameter int NOC_RADIX = 16,
  parameter int DEST = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [15:0]       i_num_pkts,
  input  logic [3:0]        i_pkt_flits,
  noc_pkt_gen_if.master     noc,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_pkt_cnt
);
  localparam int DEST_W = $clog2(NOC_RADIX);
  localparam int VC_W = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  state_t state, nxt;
  logic [15:0] num_r;
  logic [3:0] flits_r, idx;
  logic [GAP_W-1:0] gap_cnt;
  logic acc, last_flit, last_pkt, start_ok;
  logic [31:0] word;
  logic [DATA_WIDTH-1:0] payload;
  logic [NOC_WIDTH-1:0] data;
  assign start_ok = state == IDLE && i_start;
  assign acc = noc.o_valid_out && noc.o_ready_in;
  assign last_flit = idx == flits_r - 4'd1;
  assign last_pkt = o_pkt_cnt == num_r - 16'd1;
  assign noc.o_valid_out = state == SEND;
  assign noc.o_data_out = data;
  assign o_busy = state == SEND || state == GAP;
  assign o_done = state == DONE;
`ifdef PKT_GEN_LFSR_EN
  pkt_gen_lfsr u_lfsr (.clk(clk), .reset(reset), .advance(acc), .value(word));
`else
  assign word = {o_pkt_cnt, 12'd0, idx};
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (i_start ? (i_num_pkts == 16'd0 ? DONE : SEND) : IDLE)
        : state == SEND ? (acc && last_flit ? (last_pkt ? DONE : (GAP_CYCLES > 0 ? GAP : SEND)) : SEND)
        : state == GAP  ? (gap_cnt == GAP_W'(GAP_CYCLES - 1) ? SEND : GAP)
        : IDLE;
  // o_pkt_cnt doubles as the sequence number of the packet being sent
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      num_r <= '0;
      flits_r <= '0;
      idx <= '0;
      gap_cnt <= '0;
      o_pkt_cnt <= '0;
    end else begin
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      if (start_ok) begin
        num_r <= i_num_pkts;
        flits_r <= i_pkt_flits == 4'd0 ? 4'd1 : i_pkt_flits;
        idx <= '0;
        o_pkt_cnt <= '0;
      end else if (acc) begin
        idx <= last_flit ? '0 : idx + 1'b1;
        if (last_flit) o_pkt_cnt <= o_pkt_cnt + 1'b1;
      end
    end
  always_comb begin
    payload = DATA_WIDTH'({(DATA_WIDTH + 31) / 32{word}});
    if (idx == 4'd0) payload[63:0] = sop_header(o_pkt_cnt, flits_r);
    data = '0;
    if (state == SEND) begin
      data[DATA_WIDTH-1:0] = payload;
      data[DATA_WIDTH+SOP_OFF] = idx == 4'd0;
      data[DATA_WIDTH+EOP_OFF] = last_flit;
      data[DATA_WIDTH+DEST_OFF +: DEST_W] = DEST_W'(DEST);
      data[DATA_WIDTH+DEST_OFF+DEST_W +: VC_W] = VC_W'(o_pkt_cnt % NUM_VC);
    end
  end
endmodule

// File: tb/tb_noc_pkt_gen.sv
// tb_noc_pkt_gen: directed and randomized checks of noc_pkt_gen against a flit-list reference model
module tb_noc_pkt_gen;
  localparam int NW = 600;
  localparam int DW = 512;
  localparam int G = 2;
  logic clk = 0, reset = 0, i_start = 0;
  logic [15:0] i_num_pkts = 0;
  logic [3:0] i_pkt_flits = 0;
  logic o_busy, o_done;
  logic [15:0] o_pkt_cnt;
  int n_assert = 0, n_fail = 0, cyc = 0, t0 = 0;
  logic [NW-1:0] got[$];
  int got_cyc[$];
  int done_q[$];
  logic prev_stall = 0;
  logic [NW-1:0] prev_data = '0;
`ifdef PKT_GEN_LFSR_EN
  logic [31:0] m_lfsr = 32'h1;
`endif
  noc_pkt_gen_if #(.NOC_WIDTH(NW)) noc ();
  noc_pkt_gen dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_num_pkts(i_num_pkts),
    .i_pkt_flits(i_pkt_flits), .noc(noc.master), .o_busy(o_busy),
    .o_done(o_done), .o_pkt_cnt(o_pkt_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (prev_stall && reset) begin
      chk("hold_valid", NW'(noc.o_valid_out), NW'(1));
      chk("hold_data", noc.o_data_out, prev_data);
    end
    prev_stall = noc.o_valid_out && !noc.o_ready_in;
    prev_data = noc.o_data_out;
    if (noc.o_valid_out && noc.o_ready_in) begin
      got.push_back(noc.o_data_out);
      got_cyc.push_back(cyc - t0);
    end
    if (o_done) done_q.push_back(cyc - t0);
  end
  function automatic logic [NW-1:0] exp_flit(input int p, input int f, input int F, input logic [31:0] w);
    logic [NW-1:0] d = '0;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = w;
    if (f == 0) d[63:0] = {32'h0, 12'h86D, 4'(F), 16'(p)};
    d[DW] = f == 0;
    d[DW+1] = f == F - 1;
    d[DW+8 +: 4] = 4'd4;
    d[DW+12] = 1'(p % 2);
    return d;
  endfunction
  task automatic start(input int n, input int f);
    @(posedge clk); #1;
    i_num_pkts = 16'(n);
    i_pkt_flits = 4'(f);
    i_start = 1;
    t0 = cyc;
    got.delete();
    got_cyc.delete();
    done_q.delete();
    @(posedge clk); #1;
    i_start = 0;
  endtask
  task automatic wait_done(input int budget, input bit rnd);
    for (int i = 0; i < budget && done_q.size() == 0; i++) begin
      @(posedge clk); #1;
      if (rnd) noc.o_ready_in = $urandom_range(0, 3) != 0;
    end
    noc.o_ready_in = 1;
  endtask
  task automatic check_run(input int n, input int f_in, input bit timed);
    int F = f_in == 0 ? 1 : f_in;
    int k;
    logic [31:0] w;
    chk("flit_count", NW'(got.size()), NW'(n * F));
    for (int p = 0; p < n; p++)
      for (int f = 0; f < F; f++) begin
        k = p * F + f;
`ifdef PKT_GEN_LFSR_EN
        w = m_lfsr;
        m_lfsr = m_lfsr[0] ? (m_lfsr >> 1) ^ 32'h8020_0003 : m_lfsr >> 1;
`else
        w = {16'(p), 16'(f)};
`endif
        if (k < got.size()) begin
          chk($sformatf("flit_p%0d_f%0d", p, f), got[k], exp_flit(p, f, F, w));
          if (timed) chk($sformatf("cycle_p%0d_f%0d", p, f), NW'(got_cyc[k]), NW'(1 + p * (F + G) + f));
        end
      end
    chk("done_pulses", NW'(done_q.size()), NW'(1));
    if (timed) chk("done_cycle", NW'(done_q.size() > 0 ? done_q[0] : -1), NW'(n == 0 ? 1 : (n - 1) * (F + G) + F + 1));
    chk("pkt_cnt", NW'(o_pkt_cnt), NW'(n));
  endtask
  initial begin
    int n, f;
    noc.o_ready_in = 1;
    #3;
    chk("rst_valid", NW'(noc.o_valid_out), NW'(0));
    chk("rst_data", noc.o_data_out, NW'(0));
    chk("rst_busy", NW'(o_busy), NW'(0));
    chk("rst_done", NW'(o_done), NW'(0));
    chk("rst_pkt_cnt", NW'(o_pkt_cnt), NW'(0));
    @(posedge clk); #1;
    reset = 1;
    start(3, 2);
    wait_done(60, 0);
    check_run(3, 2, 1);
    start(1, 1);
    wait_done(60, 0);
    check_run(1, 1, 1);
    start(2, 4);
    for (int i = 0; i < 20 && got.size() < 1; i++) begin @(posedge clk); #1; end
    noc.o_ready_in = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_count", NW'(got.size()), NW'(1));
    noc.o_ready_in = 1;
    wait_done(60, 0);
    check_run(2, 4, 0);
    start(4, 2);
    wait_done(80, 0);
    check_run(4, 2, 1);
    for (int p = 0; p < 4 && 2 * p < got.size(); p++) chk($sformatf("vc_p%0d", p), NW'(got[2*p][DW+12]), NW'(p % 2));
    start(0, 3);
    wait_done(20, 0);
    check_run(0, 3, 1);
    start(2, 3);
    i_num_pkts = 16'd5;
    i_start = 1;
    @(posedge clk); #1;
    i_start = 0;
    chk("busy_during_run", NW'(o_busy), NW'(1));
    wait_done(60, 0);
    check_run(2, 3, 1);
    start(2, 3);
    #2;
    reset = 0;
    #1;
    chk("mid_rst_valid", NW'(noc.o_valid_out), NW'(0));
    chk("mid_rst_data", noc.o_data_out, NW'(0));
    chk("mid_rst_busy", NW'(o_busy), NW'(0));
`ifdef PKT_GEN_LFSR_EN
    m_lfsr = 32'h1;
`endif
    got.delete();
    @(posedge clk); #1;
    reset = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_flits_after_rst", NW'(got.size()), NW'(0));
    chk("idle_after_rst", NW'(o_busy), NW'(0));
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 4);
      f = $urandom_range(0, 5);
      start(n, f);
      wait_done(400, 1);
      check_run(n, f, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
